// File: rtl/data_delay_mc_if.sv
// Bus bundle for data_delay_mc: delay programming, input samples and
// delayed outputs. The master side drives samples and delay requests, the
// slave side (the delay line) returns the delayed samples and the error flag.
interface data_delay_mc_if #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int MAX_DELAY = 15
);
  localparam int DELAY_WIDTH = $clog2(MAX_DELAY + 1);

  logic [CHANNELS*DELAY_WIDTH-1:0] delay;
  logic                            delay_load;
  logic                            in_valid;
  logic [CHANNELS*WIDTH-1:0]       in;
  logic [CHANNELS-1:0]             out_valid;
  logic [CHANNELS*WIDTH-1:0]       out;
  logic                            delay_err;

  modport master (
    output delay, delay_load, in_valid, in,
    input  out_valid, out, delay_err
  );

  modport slave (
    input  delay, delay_load, in_valid, in,
    output out_valid, out, delay_err
  );
endinterface

// File: rtl/data_delay_mc.sv
// Multi-channel variable delay line qualified by in_valid. Each lane keeps a
// MAX_DELAY-deep history of accepted samples and outputs the sample d[c]
// accepted samples back (d=0 passes the current sample through). Output
// valids stay low until the shared fill counter shows enough history for the
// lane's delay, so stale or unreset history is never exposed.
module data_delay_mc #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int MAX_DELAY = 15
) (
  input  logic           clk,
  input  logic           rst,
  data_delay_mc_if.slave bus
);
  localparam int DELAY_WIDTH = $clog2(MAX_DELAY + 1);
  localparam logic [DELAY_WIDTH-1:0] MAX_D = DELAY_WIDTH'(MAX_DELAY);

  // History slot k holds history index k+1 (slot 0 is the newest prior sample).
  logic [WIDTH-1:0]          hist_q [CHANNELS][MAX_DELAY];
  logic [WIDTH-1:0]          hist_d [CHANNELS][MAX_DELAY];
  logic [DELAY_WIDTH-1:0]    dly_q  [CHANNELS];
  logic [DELAY_WIDTH-1:0]    dly_d  [CHANNELS];
  logic [DELAY_WIDTH-1:0]    fill_q;
  logic [DELAY_WIDTH-1:0]    fill_d;
  logic [CHANNELS-1:0]       out_valid_q;
  logic [CHANNELS-1:0]       out_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_q;
  logic [CHANNELS*WIDTH-1:0] out_d;
  logic                      delay_err_q;
  logic                      delay_err_d;
  logic [WIDTH-1:0]          sel    [CHANNELS];

  // Shift accepted samples into the history; a reset cycle drops the sample.
  always_comb begin
    hist_d = hist_q;
    if (bus.in_valid && !rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hist_d[c][0] = bus.in[c*WIDTH +: WIDTH];
        for (int k = 1; k < MAX_DELAY; k++) begin
          hist_d[c][k] = hist_q[c][k-1];
        end
      end
    end
  end

  // History carries no reset: the fill counter keeps unwritten slots hidden.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  // Pick the current sample for d=0, otherwise history index d.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sel[c] = bus.in[c*WIDTH +: WIDTH];
      for (int k = 1; k <= MAX_DELAY; k++) begin
        if (dly_q[c] == DELAY_WIDTH'(k)) begin
          sel[c] = hist_q[c][k-1];
        end
      end
    end
  end

  // Latch clamped delay requests and raise the sticky error on any overrange field.
  always_comb begin
    dly_d       = dly_q;
    delay_err_d = delay_err_q;
    if (bus.delay_load) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if ({1'b0, bus.delay[c*DELAY_WIDTH +: DELAY_WIDTH]} > {1'b0, MAX_D}) begin
          dly_d[c]    = MAX_D;
          delay_err_d = 1'b1;
        end else begin
          dly_d[c] = bus.delay[c*DELAY_WIDTH +: DELAY_WIDTH];
        end
      end
    end
  end

  // Count accepted samples up to MAX_DELAY; all lanes share in_valid so one counter serves all.
  always_comb begin
    fill_d = fill_q;
    if (bus.in_valid && (fill_q != MAX_D)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  // Produce the next output word: valid only once enough history exists, hold on gaps.
  always_comb begin
    out_valid_d = '0;
    out_d       = out_q;
    if (bus.in_valid) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (fill_q >= dly_q[c]) begin
          out_valid_d[c]              = 1'b1;
          out_d[c*WIDTH +: WIDTH]     = sel[c];
        end else begin
          out_d[c*WIDTH +: WIDTH]     = '0;
        end
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q       <= '{default: '0};
      fill_q      <= '0;
      out_valid_q <= '0;
      out_q       <= '0;
      delay_err_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      delay_err_q <= delay_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.delay_err = delay_err_q;
endmodule

// File: doc/data_delay_mc.md
# data_delay_mc

Multi-channel, sample-qualified variable delay line with a registered output. Each of CHANNELS independent lanes delays its WIDTH-bit sample by a run-time delay of 0..MAX_DELAY valid samples. Per-lane output valids are held low until enough history exists, and out-of-range delay requests are clamped and flagged. It sits in the sync datapath wherever streams with gaps (in_valid duty < 100 %) or several lanes need programmable alignment.

## Interface
- WIDTH, 16: sample width per channel, ≥ 1.
- CHANNELS, 2: number of independent lanes, ≥ 1.
- MAX_DELAY, 15: maximum delay in valid samples, ≥ 1.
- DELAY_WIDTH, $clog2(MAX_DELAY+1): derived localparam, width of one delay field.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- delay  in  CHANNELS*DELAY_WIDTH  requested delay; lane c at [c*DELAY_WIDTH +: DELAY_WIDTH].
- delay_load  in  1  strobe; latches all lanes of delay into the active delay registers.
- in_valid  in  1  qualifies in; one sample per lane per asserted cycle.
- in  in  CHANNELS*WIDTH  input samples; lane c at [c*WIDTH +: WIDTH].
- out_valid  out  CHANNELS  per-lane output valid.
- out  out  CHANNELS*WIDTH  delayed samples, registered.
- delay_err  out  1  sticky: a loaded delay field exceeded MAX_DELAY.

## Operation
- Storage per lane: MAX_DELAY-deep history of accepted samples, advanced only on in_valid=1. Index 1 is the newest prior sample, MAX_DELAY the oldest. The history is not reset.
- Active delay d[c]: a register per lane, reset to 0. On delay_load=1, d[c] loads min(delay field, MAX_DELAY).
- Clamping: if any field is greater than MAX_DELAY, delay_err is set to 1. It stays set until rst.
- Fill counter f[c] per lane, DELAY_WIDTH bits, reset to 0:
  - Increments on each in_valid=1 cycle.
  - Saturates at MAX_DELAY.
  - Not cleared by delay_load, because the stored history stays valid across delay changes.
  - All lanes share in_valid, so every f[c] is equal; it may be implemented as a single shared counter.
- Selection, on an in_valid=1 cycle, using the values before the clock edge:
  - d[c]=0: the selected sample is in itself.
  - d[c]≥1: the selected sample is history index d[c].
- Per-lane output update on an in_valid=1 cycle:
  - If f[c] ≥ d[c]: out_valid[c]←1 and out[c]←selected sample.
  - Otherwise: out_valid[c]←0 and out[c]←0.
- On an in_valid=0 cycle: out_valid←0, out holds its value, history and f hold.
- A delay change takes effect immediately on the next accepted sample:
  - Decrease: some samples are skipped.
  - Increase: some samples are repeated.
  - No flush. Valid gating applies only while f < d.
- Reset values: out=0, out_valid=0, delay_err=0, d=0, f=0.
- Reset mid-stream: all of the above return to reset values on the next edge. History contents are don't-care, and f=0 guarantees they are never exposed.

## Timing
- Latency: the sample accepted at edge n, with d=0, appears on out at edge n (visible in cycle n+1). Fixed latency is 1 clock plus d valid samples.
- delay_load at edge n: the new d applies to samples accepted at edge n+1 onward. A sample accepted at edge n uses the old d.
- delay_load and in_valid in the same cycle are legal: the sample uses the old d, and history still shifts.
- delay_load and rst in the same cycle: rst wins, so d=0 and delay_err=0.
- in_valid and rst in the same cycle: the sample is dropped and history does not advance.
- Saturation: f stays at MAX_DELAY. Selection at d=MAX_DELAY reads the oldest entry, with no wrap artefacts.
- Throughput: one sample per lane per clock, with no stall or backpressure.
- Critical path: a MAX_DELAY+1 : 1 mux per lane, plus the compare f ≥ d.

## Test plan
Parameters: WIDTH=8, CHANNELS=2, MAX_DELAY=5.
1. Reset check: hold rst for 3 cycles with in_valid=1 and in=0xFFFF.
   - Required: out=0, out_valid=00, delay_err=0 throughout.
2. Zero and fixed delay:
   - Stimulus: d={3,0}; after release, continuous in_valid with lane0=1,2,3,… and lane1=0x10,0x11,….
   - Lane1: out_valid[1]=1 from the first sample, out=0x10,0x11,….
   - Lane0: out_valid[0]=0 for the first 3 samples, then out=1,2,3,….
3. Gapped input:
   - Stimulus: d={2,2}; in_valid pattern 1,0,0,1,1,0,1 carrying 0xA,–,–,0xB,0xC,–,0xD.
   - Required: out_valid asserts only on the accepted cycles whose f is at least 2. The 3rd accepted sample outputs 0xA and the 4th outputs 0xB. out holds on the gap cycles.
4. Runtime change:
   - Stimulus: with the stream running at d0=4, load d0=1 and then d0=5.
   - Required: the decrease skips 3 samples in the output sequence; the increase repeats 4. out_valid stays 1 because f is already saturated at 5.
5. Clamp: load delay field 7 on lane0.
   - Required: d0=5 is used (output equals the sample accepted 5 valid samples earlier), and delay_err=1 stays set until rst.
6. Mid-stream reset: with d0=3 and the stream running, pulse rst for 1 cycle.
   - Required: out_valid[0]=0 for the next 3 accepted samples, with no pre-reset data ever appearing. Note that d returns to 0 unless reloaded, so reload d0=3 in the same test.
